// File: rtl/bit_cntr_pkg.sv
// Shared sizing helpers for the streaming popcount: granule count, tree depth,
// latency and result width, plus the per-beat sideband carried down the pipe.
package bit_cntr_pkg;

  function automatic int clog2(input int v);
    int r;
    int x;
    r = 0;
    x = 1;
    while (x < v) begin
      x = x * 2;
      r++;
    end
    return r;
  endfunction

  function automatic int ng_f(input int vw, input int gw);
    return (vw + gw - 1) / gw;
  endfunction

  function automatic int tl_f(input int ng);
    return clog2(ng);
  endfunction

  function automatic int lat_f(input int tl);
    return tl + 2;
  endfunction

  function automatic int sum_w_f(input int vw, input int max_beats);
    return clog2(vw * max_beats + 1);
  endfunction

  function automatic int gsum_w_f(input int gw);
    return clog2(gw + 1);
  endfunction

  // Node count of tree level lvl (level 0 = granule counts).
  function automatic int nodes_f(input int ng, input int lvl);
    int n;
    n = ng;
    for (int j = 0; j < lvl; j++) n = (n + 1) / 2;
    return n;
  endfunction

  // Bit offset of level lvl in the flattened tree bus; node width grows 1 bit/level.
  function automatic int tree_off_f(input int ng, input int gsw, input int lvl);
    int o;
    o = 0;
    for (int j = 0; j < lvl; j++) o += nodes_f(ng, j) * (gsw + j);
    return o;
  endfunction

  localparam int GRAN_W_DEF = 6;
  localparam int GSUM_W     = gsum_w_f(GRAN_W_DEF);

  typedef struct packed {
    logic vld;
    logic last;
  } beat_side_t;

endpackage

// File: rtl/granule_popcnt.sv
// Popcount of one granule; a GRANULE_WIDTH-input function, so each output bit
// maps onto a single LUT.
module granule_popcnt
  import bit_cntr_pkg::*;
#(
  parameter  int GRANULE_WIDTH = GRAN_W_DEF,
  localparam int CW            = gsum_w_f(GRANULE_WIDTH)
) (
  input  logic [GRANULE_WIDTH-1:0] gran_i,
  output logic [CW-1:0]            cnt_o
);

  always_comb begin
    cnt_o = '0;
    for (int b = 0; b < GRANULE_WIDTH; b++) cnt_o = cnt_o + CW'(gran_i[b]);
  end

endmodule

// File: rtl/bit_cntr_stream.sv
// Streaming pipelined popcount with multi-beat accumulation, threshold hit and
// saturation/overflow flag; a single global advance stalls every stage.
module bit_cntr_stream
  import bit_cntr_pkg::*;
#(
  parameter  int VECTOR_WIDTH  = 64,
  parameter  int GRANULE_WIDTH = 6,
  parameter  int MAX_BEATS     = 4,
  localparam int SUM_W         = sum_w_f(VECTOR_WIDTH, MAX_BEATS)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [VECTOR_WIDTH-1:0] i_Vector,
  input  logic                    i_Valid,
  input  logic                    i_Last,
  input  logic [SUM_W-1:0]        i_Threshold,
  output logic                    o_Ready,
  output logic                    o_Valid,
  input  logic                    i_Ready,
  output logic [SUM_W-1:0]        o_Sum,
  output logic                    o_Hit,
  output logic                    o_Ovf
);

  localparam int NG      = ng_f(VECTOR_WIDTH, GRANULE_WIDTH);
  localparam int TL      = tl_f(NG);
  localparam int GS_W    = gsum_w_f(GRANULE_WIDTH);
  localparam int BW      = GS_W + TL;
  localparam int PAD_W   = NG * GRANULE_WIDTH;
  localparam int TOP_OFF = tree_off_f(NG, GS_W, TL);
  localparam int TREE_W  = tree_off_f(NG, GS_W, TL + 1);
  localparam int SAT     = VECTOR_WIDTH * MAX_BEATS;
  localparam int CNT_W   = clog2(MAX_BEATS + 2);

  localparam logic [SUM_W:0]   SAT_W1  = (SUM_W + 1)'(SAT);
  localparam logic [SUM_W-1:0] SAT_S   = SUM_W'(SAT);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_BEATS);

  logic adv;
  logic [PAD_W-1:0] vec_pad;

  // Every tree level lives in one flat bus; _d of level k is built from _q of level k-1.
  wire  [TREE_W-1:0] tree_d;
  logic [TREE_W-1:0] tree_q;

  beat_side_t [TL:0]            side_q;
  logic       [TL:0][SUM_W-1:0] thr_q;

  logic [BW-1:0]    beat_sum;
  logic [SUM_W:0]   tot;
  logic [SUM_W-1:0] acc_nx;
  logic [CNT_W-1:0] cnt_nx;
  logic             ovf_nx;

  logic [SUM_W-1:0] acc_q, acc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             run_ovf_q, run_ovf_d;
  logic             valid_q, valid_d;
  logic [SUM_W-1:0] sum_q, sum_d;
  logic             hit_q, hit_d;
  logic             ovf_q, ovf_d;

  assign adv     = ~valid_q | i_Ready;
  assign o_Ready = adv;
  assign o_Valid = valid_q;
  assign o_Sum   = sum_q;
  assign o_Hit   = hit_q;
  assign o_Ovf   = ovf_q;

  assign vec_pad = PAD_W'(i_Vector);

  for (genvar g = 0; g < NG; g++) begin : g_gran
    granule_popcnt #(.GRANULE_WIDTH(GRANULE_WIDTH)) u_pc (
      .gran_i (vec_pad[g*GRANULE_WIDTH +: GRANULE_WIDTH]),
      .cnt_o  (tree_d[g*GS_W +: GS_W])
    );
  end

  for (genvar k = 1; k <= TL; k++) begin : g_lvl
    localparam int NI = nodes_f(NG, k - 1);
    localparam int NO = nodes_f(NG, k);
    localparam int WI = GS_W + k - 1;
    localparam int WO = GS_W + k;
    localparam int OI = tree_off_f(NG, GS_W, k - 1);
    localparam int OO = tree_off_f(NG, GS_W, k);
    for (genvar n = 0; n < NO; n++) begin : g_node
      if (2*n + 1 < NI) begin : g_add
        assign tree_d[OO + n*WO +: WO] = WO'(tree_q[OI + 2*n*WI +: WI])
                                       + WO'(tree_q[OI + (2*n+1)*WI +: WI]);
      end else begin : g_pass
        assign tree_d[OO + n*WO +: WO] = WO'(tree_q[OI + 2*n*WI +: WI]);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tree_q <= '0;
      side_q <= '0;
      thr_q  <= '0;
    end else if (adv) begin
      tree_q         <= tree_d;
      side_q[0].vld  <= i_Valid;
      side_q[0].last <= i_Valid & i_Last;
      thr_q[0]       <= i_Last ? i_Threshold : '0;
      for (int s = 1; s <= TL; s++) begin
        side_q[s] <= side_q[s-1];
        thr_q[s]  <= thr_q[s-1];
      end
    end
  end

  // Beat-count saturates one past MAX_BEATS so a long vector stays flagged.
  assign beat_sum = tree_q[TOP_OFF +: BW];
  assign tot      = (SUM_W + 1)'(acc_q) + (SUM_W + 1)'(beat_sum);
  assign acc_nx   = (tot > SAT_W1) ? SAT_S : tot[SUM_W-1:0];
  assign cnt_nx   = (cnt_q > CNT_MAX) ? cnt_q : cnt_q + CNT_W'(1);
  assign ovf_nx   = run_ovf_q | (tot > SAT_W1) | (cnt_nx > CNT_MAX);

  always_comb begin
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    run_ovf_d = run_ovf_q;
    valid_d   = valid_q;
    sum_d     = sum_q;
    hit_d     = hit_q;
    ovf_d     = ovf_q;
    if (adv) begin
      valid_d = 1'b0;
      if (side_q[TL].vld) begin
        if (side_q[TL].last) begin
          valid_d   = 1'b1;
          sum_d     = acc_nx;
          hit_d     = (acc_nx >= thr_q[TL]);
          ovf_d     = ovf_nx;
          acc_d     = '0;
          cnt_d     = '0;
          run_ovf_d = 1'b0;
        end else begin
          acc_d     = acc_nx;
          cnt_d     = cnt_nx;
          run_ovf_d = ovf_nx;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_q     <= '0;
      cnt_q     <= '0;
      run_ovf_q <= 1'b0;
      valid_q   <= 1'b0;
      sum_q     <= '0;
      hit_q     <= 1'b0;
      ovf_q     <= 1'b0;
    end else begin
      acc_q     <= acc_d;
      cnt_q     <= cnt_d;
      run_ovf_q <= run_ovf_d;
      valid_q   <= valid_d;
      sum_q     <= sum_d;
      hit_q     <= hit_d;
      ovf_q     <= ovf_d;
    end
  end

endmodule

// File: tb/tb_bit_cntr_stream.sv
// Bench for bit_cntr_stream: vector table plus latency, backpressure, reset and
// random-stream sequences, all results checked through an in-order scoreboard.
module tb_bit_cntr_stream;

  localparam int VW = 64;
  localparam int SW = 9;

  typedef struct packed {
    logic [SW-1:0] sum;
    logic          hit;
    logic          ovf;
  } exp_t;

  typedef struct packed {
    logic [5:0][VW-1:0] v;
    logic [2:0]         n;
    logic [SW-1:0]      thr;
    exp_t               e;
  } vec_t;

  logic          clk;
  logic          rst;
  logic [VW-1:0] i_Vector;
  logic          i_Valid;
  logic          i_Last;
  logic [SW-1:0] i_Threshold;
  logic          o_Ready;
  logic          o_Valid;
  logic          i_Ready;
  logic [SW-1:0] o_Sum;
  logic          o_Hit;
  logic          o_Ovf;

  exp_t sb_q[$];
  int   n_pass = 0;
  int   n_chk  = 0;
  int   cyc    = 0;
  bit   rnd_done;

  bit_cntr_stream dut (
    .clk         (clk),
    .rst         (rst),
    .i_Vector    (i_Vector),
    .i_Valid     (i_Valid),
    .i_Last      (i_Last),
    .i_Threshold (i_Threshold),
    .o_Ready     (o_Ready),
    .o_Valid     (o_Valid),
    .i_Ready     (i_Ready),
    .o_Sum       (o_Sum),
    .o_Hit       (o_Hit),
    .o_Ovf       (o_Ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #900000;
    $display("FAIL watchdog: simulation still running at %0t", $time);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
  endtask

  // Every output handshake consumes exactly one expected result, in order.
  always @(negedge clk) begin
    if (!rst && o_Valid && i_Ready) begin
      if (sb_q.size() == 0) begin
        n_chk++;
        $display("FAIL spurious_valid: got o_Sum=%0d with no result expected", o_Sum);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        chk("sb_sum", int'(o_Sum), int'(e.sum));
        chk("sb_hit", int'(o_Hit), int'(e.hit));
        chk("sb_ovf", int'(o_Ovf), int'(e.ovf));
      end
    end
  end

  function automatic exp_t model(input logic [5:0][VW-1:0] v, input int n, input logic [SW-1:0] thr);
    int   s;
    exp_t e;
    s = 0;
    for (int b = 0; b < n; b++) s += $countones(v[b]);
    e.sum = (s > 256) ? SW'(256) : SW'(s);
    e.ovf = (s > 256) || (n > 4);
    e.hit = (e.sum >= thr);
    return e;
  endfunction

  function automatic vec_t mk(input int n, input logic [VW-1:0] v0, input logic [VW-1:0] v1,
                              input logic [VW-1:0] v2, input int thr, input int s,
                              input bit h, input bit o);
    vec_t t;
    t = '0;
    for (int b = 0; b < 6; b++) t.v[b] = (b == 0) ? v0 : (b == 1) ? v1 : v2;
    t.n     = 3'(n);
    t.thr   = SW'(thr);
    t.e.sum = SW'(s);
    t.e.hit = h;
    t.e.ovf = o;
    return t;
  endfunction

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Non-last beats carry junk thresholds: only the last-beat value may matter.
  task automatic send_beat(input logic [VW-1:0] v, input bit last, input logic [SW-1:0] thr,
                           output bit ok);
    bit rdy;
    i_Vector    = v;
    i_Valid     = 1'b1;
    i_Last      = last;
    i_Threshold = last ? thr : SW'($urandom);
    ok          = 1'b0;
    for (int n = 0; n < 200; n++) begin
      @(negedge clk);
      rdy = o_Ready;
      @(posedge clk);
      #1;
      if (rdy) begin
        ok = 1'b1;
        break;
      end
    end
    i_Valid = 1'b0;
    i_Last  = 1'b0;
  endtask

  task automatic send_vec(input vec_t t, input int gapmax);
    bit ok;
    for (int b = 0; b < int'(t.n); b++) begin
      if (gapmax > 0) idle($urandom_range(0, gapmax));
      send_beat(t.v[b], b == int'(t.n) - 1, t.thr, ok);
      if (!ok) begin
        n_chk++;
        $display("FAIL accept_timeout: beat %0d not accepted, o_Ready=%0d required 1", b, o_Ready);
        return;
      end
      if (b == int'(t.n) - 1) sb_q.push_back(t.e);
    end
  endtask

  task automatic drain();
    for (int n = 0; n < 500; n++) begin
      if (sb_q.size() == 0) break;
      @(posedge clk);
      #1;
    end
    if (sb_q.size() != 0) begin
      n_chk++;
      $display("FAIL drain: %0d results outstanding, required 0", sb_q.size());
      sb_q.delete();
    end
    idle(3);
  endtask

  function automatic vec_t rnd_vec(input int nmax);
    vec_t t;
    int   n;
    t = '0;
    n = $urandom_range(1, nmax);
    for (int b = 0; b < 6; b++)
      t.v[b] = ($urandom_range(0, 7) == 0) ? '1 : {$urandom(), $urandom()};
    t.n   = 3'(n);
    t.thr = SW'($urandom_range(0, 300));
    t.e   = model(t.v, n, t.thr);
    return t;
  endfunction

  vec_t           tbl[12];
  logic [VW-1:0]  ones;
  int             lat;
  int             c0;
  bit             ok;

  initial begin
    ones   = '1;
    tbl[0]  = mk(1, ones, 0, 0, 64, 64, 1'b1, 1'b0);
    tbl[1]  = mk(1, ones, 0, 0, 65, 64, 1'b0, 1'b0);
    tbl[2]  = mk(3, 64'h1, 64'hFF, ones, 100, 73, 1'b0, 1'b0);
    tbl[3]  = mk(5, ones, ones, ones, 0, 256, 1'b1, 1'b1);
    tbl[4]  = mk(1, 64'hF, 0, 0, 5, 4, 1'b0, 1'b0);
    tbl[5]  = mk(4, ones, ones, ones, 256, 256, 1'b1, 1'b0);
    tbl[6]  = mk(1, 0, 0, 0, 0, 0, 1'b1, 1'b0);
    tbl[7]  = mk(1, 64'hAAAA_AAAA_AAAA_AAAA, 0, 0, 32, 32, 1'b1, 1'b0);
    tbl[8]  = mk(5, 64'h1, 64'h1, 64'h1, 6, 5, 1'b0, 1'b1);
    tbl[9]  = mk(6, 64'h3, 64'h3, 64'h3, 12, 12, 1'b1, 1'b1);
    tbl[10] = mk(2, ones, ones, 0, 129, 128, 1'b0, 1'b0);
    tbl[11] = mk(4, ones, ones, 64'h8000_0000_0000_0001, 133, 132, 1'b0, 1'b0);

    rst = 1'b0; i_Vector = '0; i_Valid = 1'b0; i_Last = 1'b0;
    i_Threshold = '0; i_Ready = 1'b1;
    #1 rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_valid", int'(o_Valid), 0);
    chk("rst_sum", int'(o_Sum), 0);
    chk("rst_hit", int'(o_Hit), 0);
    chk("rst_ovf", int'(o_Ovf), 0);
    chk("rst_ready", int'(o_Ready), 1);
    @(posedge clk);
    #1 rst = 1'b0;
    idle(2);

    // First-result latency from an idle pipe.
    i_Vector = ones; i_Last = 1'b1; i_Threshold = 9'd64; i_Valid = 1'b1;
    sb_q.push_back(exp_t'{9'd64, 1'b1, 1'b0});
    lat = 0;
    for (int n = 1; n <= 20; n++) begin
      @(posedge clk);
      #1;
      if (n == 1) begin
        i_Valid = 1'b0;
        i_Last  = 1'b0;
      end
      if (o_Valid) begin
        lat = n;
        break;
      end
    end
    chk("latency", lat, 6);
    drain();

    for (int i = 0; i < 12; i++) send_vec(tbl[i], 0);
    drain();

    // Hold i_Ready low for 4 cycles with a result showing and beats still arriving.
    fork
      begin
        for (int i = 0; i < 6; i++) send_vec(rnd_vec(2), 0);
      end
      begin
        bit seen;
        seen = 1'b0;
        @(posedge clk);
        #1 i_Ready = 1'b0;
        for (int n = 0; n < 100; n++) begin
          @(negedge clk);
          if (o_Valid) begin
            seen = 1'b1;
            break;
          end
        end
        if (!seen) begin
          n_chk++;
          $display("FAIL bp_wait: o_Valid=0 after 100 cycles, required 1");
        end else begin
          for (int s = 0; s < 4; s++) begin
            if (s > 0) @(negedge clk);
            chk("bp_ready", int'(o_Ready), 0);
            chk("bp_valid", int'(o_Valid), 1);
            if (sb_q.size() > 0) begin
              chk("bp_sum", int'(o_Sum), int'(sb_q[0].sum));
              chk("bp_hit", int'(o_Hit), int'(sb_q[0].hit));
              chk("bp_ovf", int'(o_Ovf), int'(sb_q[0].ovf));
            end
          end
        end
        @(posedge clk);
        #1 i_Ready = 1'b1;
      end
    join
    drain();

    // Reset with a partial vector in flight: it must vanish without a result.
    send_beat(ones, 1'b0, '0, ok);
    chk("rstmid_beat0", int'(ok), 1);
    send_beat(ones, 1'b0, '0, ok);
    chk("rstmid_beat1", int'(ok), 1);
    rst = 1'b1;
    @(negedge clk);
    chk("rstmid_valid", int'(o_Valid), 0);
    chk("rstmid_sum", int'(o_Sum), 0);
    chk("rstmid_hit", int'(o_Hit), 0);
    chk("rstmid_ovf", int'(o_Ovf), 0);
    chk("rstmid_ready", int'(o_Ready), 1);
    @(posedge clk);
    #1 rst = 1'b0;
    send_vec(mk(1, 64'h3, 0, 0, 2, 2, 1'b1, 1'b0), 0);
    drain();

    // Back-to-back beats with i_Ready held high: one acceptance per cycle.
    c0 = cyc;
    for (int i = 0; i < 20; i++) send_vec(rnd_vec(1), 0);
    chk("throughput_cycles", cyc - c0, 20);
    drain();

    rnd_done = 1'b0;
    fork
      begin
        for (int i = 0; i < 1000; i++)
          send_vec(rnd_vec(5), ($urandom_range(0, 3) == 0) ? 2 : 0);
        rnd_done = 1'b1;
      end
      begin
        while (!rnd_done) begin
          @(posedge clk);
          #1 i_Ready = ($urandom_range(0, 3) != 0);
        end
        i_Ready = 1'b1;
      end
    join
    i_Ready = 1'b1;
    drain();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
